// File: rtl/utopia_tx_poll_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : utopia_tx_poll_arbiter
// Description : Transmit-side Utopia Level-2 multi-PHY poll/select sequencer.
//               It shares one transmit Utopia interface between NumPhy PHY
//               addresses in round-robin order. For each PHY it polls clav and
//               then sequences one full cell transfer. It drives en/soc and
//               pops words from the core's cell buffer. Cell data never passes
//               through this block.
//
// Ports       : clk_in     - interface clock; all logic runs on the rising edge
//               reset_n    - asynchronous active-low reset
//               cell_req   - bit i: the core holds a cell for PHY i (level)
//               clav       - cell-available from the PHY currently addressed
//               pause      - (UTOPIA_TX_PAUSE_EN only) stalls the transfer
//               phy_addr   - PHY address being polled or served
//               en         - transmit enable, high on every cell word
//               soc        - start-of-cell, high on the first word only
//               word_rd    - pops one word from the core cell buffer (= en)
//               grant      - one-hot PHY being served; zero outside a transfer
//               cell_done  - one-cycle pulse on the last cell word
//               busy       - high in every state except IDLE
//
// Options     : UTOPIA_TX_PAUSE_EN - when defined, adds the pause input.
//               Paused XFER cycles carry no word, and the word counter holds
//               during them.
//
// Revision    : 1.0 - initial release
// ============================================================================
module utopia_tx_poll_arbiter #(
    parameter int NumPhy    = 4,
    parameter int CellWords = 53,
    parameter int AddrWidth = $clog2(NumPhy)
) (
    input  logic                 clk_in,
    input  logic                 reset_n,
    input  logic [NumPhy-1:0]    cell_req,
    input  logic                 clav,
`ifdef UTOPIA_TX_PAUSE_EN
    input  logic                 pause,
`endif
    output logic [AddrWidth-1:0] phy_addr,
    output logic                 en,
    output logic                 soc,
    output logic                 word_rd,
    output logic [NumPhy-1:0]    grant,
    output logic                 cell_done,
    output logic                 busy
);

    localparam int                   CntWidth = $clog2(CellWords + 1);
    localparam logic [CntWidth-1:0]  LastWord = CntWidth'(CellWords - 1);
    localparam logic [AddrWidth-1:0] LastPhy  = AddrWidth'(NumPhy - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_POLL  = 3'd1,
        S_CHECK = 3'd2,
        S_XFER  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [CntWidth-1:0]    cnt_q, cnt_d;
    logic [AddrWidth-1:0]   last_q, last_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic                   en_q, en_d;
    logic                   soc_q, soc_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;
    logic [NumPhy-1:0]      grant_q, grant_d;

    logic                   pick_found;
    logic [AddrWidth-1:0]   pick_addr;
    logic                   pause_w;

`ifdef UTOPIA_TX_PAUSE_EN
    assign pause_w = pause;
`else
    assign pause_w = 1'b0;
`endif

    // Round-robin choice: the first requesting PHY found by a circular
    // search that starts just after the last PHY polled or served.
    always_comb begin : p_pick
        int idx;
        idx        = 0;
        pick_found = 1'b0;
        pick_addr  = '0;
        for (int i = 1; i <= NumPhy; i++) begin
            idx = (int'(last_q) + i) % NumPhy;
            if (!pick_found && cell_req[idx]) begin
                pick_found = 1'b1;
                pick_addr  = AddrWidth'(idx);
            end
        end
    end

    always_comb begin : p_next
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        addr_d  = addr_q;

        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    addr_d  = pick_addr;
                    state_d = S_POLL;
                end
            end
            S_POLL: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (clav) begin
                    cnt_d   = '0;
                    state_d = S_XFER;
                end else begin
                    // A skipped PHY still moves the pointer on, so a PHY
                    // without room cannot starve the others.
                    last_d  = addr_q;
                    state_d = S_IDLE;
                end
            end
            S_XFER: begin
                // Only cycles that carried a word advance the count.
                // Without pause, every XFER cycle carries a word.
                if (en_q) begin
                    if (cnt_q == LastWord) begin
                        state_d = S_GAP;
                    end else begin
                        cnt_d = cnt_q + CntWidth'(1);
                    end
                end
            end
            S_GAP: begin
                last_d  = addr_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state and count. The registered
        // copies then line up with the state they describe.
        en_d    = (state_d == S_XFER) && !pause_w;
        soc_d   = en_d && (cnt_d == '0);
        done_d  = en_d && (cnt_d == LastWord);
        grant_d = (state_d == S_XFER) ? (NumPhy'(1) << addr_d) : '0;
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            last_q  <= LastPhy;
            addr_q  <= '0;
            en_q    <= 1'b0;
            soc_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            en_q    <= en_d;
            soc_q   <= soc_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            grant_q <= grant_d;
        end
    end

    assign phy_addr  = addr_q;
    assign en        = en_q;
    assign word_rd   = en_q;
    assign soc       = soc_q;
    assign grant     = grant_q;
    assign cell_done = done_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire

// File: doc/utopia_tx_poll_arbiter.md
Name: utopia_tx_poll_arbiter

Overview:
Transmit-side Utopia Level-2 multi-PHY poll/select controller. Shares the transmit Utopia interface between NumPhy PHY addresses on a round-robin basis. Per PHY it polls clav, then sequences one full cell transfer by driving en/soc and pulling words from the core's cell buffer. Sits between the CoreTransmit-side cell buffer and the PHY-facing Utopia pins. It sequences only; cell data never passes through it.

Parameters:
NumPhy, 4, number of PHY addresses arbitrated (2..16)
CellWords, 53, interface words per cell (53 for 8-bit, 27 for 16-bit IfWidth)
AddrWidth, $clog2(NumPhy), width of phy_addr (derived, not overridden)

Ports:
clk_in  input  1  interface clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
cell_req  input  NumPhy  bit i = core holds a cell destined for PHY i (level)
clav  input  1  cell-available from the currently addressed PHY
phy_addr  output  AddrWidth  PHY address being polled/served
en  output  1  transmit enable, active-high, high for every cell word
soc  output  1  start-of-cell, high on first cell word only
word_rd  output  1  pop one word from core cell buffer (equals en)
grant  output  NumPhy  one-hot PHY being served; 0 when not transferring
cell_done  output  1  one-cycle pulse on last cell word
busy  output  1  high in any state except IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs 0; phy_addr=0; word counter=0; rr pointer last=NumPhy-1, so PHY 0 has top priority first.
- All outputs are registered and decoded from state/counter.
- FSM: IDLE -> POLL -> CHECK -> XFER -> GAP -> IDLE.
- IDLE: if cell_req!=0, pick the first set bit searching circularly from last+1; load phy_addr; go to POLL. Otherwise stay.
- POLL: one cycle. phy_addr is stable so the PHY can drive clav.
- CHECK: sample clav at the end of the cycle.
  - clav=1: go to XFER with counter=0.
  - clav=0: set last=phy_addr (PHY skipped, fairness kept) and return to IDLE. No en/soc.
- XFER: lasts exactly CellWords cycles.
  - en=word_rd=1 and grant=onehot(phy_addr) on every XFER cycle.
  - soc=1 only when counter=0; counter increments each cycle.
  - cell_done=1 when counter=CellWords-1, then go to GAP.
- GAP: one cycle. en=0, grant=0, last=served address, then go to IDLE.
- Latency: a request seen in IDLE gives soc 3 cycles later (IDLE, POLL, CHECK, XFER).
  - Minimum cell period is CellWords+4 cycles.
- Request changes: cell_req is sampled only in IDLE. Deasserting a request during POLL/CHECK/XFER does not abort; the cell completes.
- clav is ignored outside CHECK.
- Counter width is $clog2(CellWords+1). No wrap occurs because the counter is cleared on entry to XFER.
- Single requester: it is re-served after GAP/IDLE. Round-robin gives no penalty when it is alone.
- Reset mid-operation: outputs drop immediately. The partial cell is abandoned and the core must flush it. The rr pointer returns to NumPhy-1.

Optional Feature:
Macro UTOPIA_TX_PAUSE_EN.
- Defined: adds input port pause (1 bit).
  - While pause=1 in XFER, en, word_rd and soc are 0 and the counter holds.
  - soc is reissued only if the counter is still 0.
  - cell_done is delayed accordingly.
  - pause is ignored in other states.
- Undefined: port absent; XFER is uninterrupted, exactly CellWords cycles.

Test Plan:
1. Assert reset_n=0 mid-idle and hold 3 cycles -> all outputs 0, phy_addr=0, busy=0.
2. cell_req=4'b0100, clav=1 -> phy_addr=2 in POLL; soc+en 3 cycles after the request cycle; 53 word_rd pulses; grant=4'b0100 throughout; cell_done on the 53rd word; en=0 in GAP.
3. cell_req=4'b1111 held, clav=1 always -> served order 0,1,2,3,0. Each cell is 53 words and cells are spaced 57 cycles apart.
4. cell_req=4'b1010, clav=0 when phy_addr=1, 1 when phy_addr=3 -> PHY1 is polled and gets no en; PHY3 is served next; the following poll goes to PHY1.
5. Serving PHY0, reset_n pulsed low at word 20 -> en/grant go to 0 asynchronously. After release with cell_req=4'b0011, PHY0 is served first with soc and a full 53 words.
6. With UTOPIA_TX_PAUSE_EN, pause=1 for 5 cycles at word 10 -> still 53 word_rd pulses total; cell_done is 5 cycles later than in test 2; exactly one soc.
